mem_load_store_seq: RTL and testbench
=====================================

// Module: mem_load_store_seq
// PURPOSE
//  Multicycle memory-access sequencer in front of the load-size/sign-extend mux.
//  Issues word-aligned reads/writes to data memory and captures the read word (MDR).
//  Extracts the addressed halfword/byte lane and presents full/half/byte plus size code.
//  Performs read-modify-write for sb/sh. Sits between control unit and data memory.
// PARAMETERS
//  MEM_LATENCY  1  cycles from mem_addr valid to mem_rdata valid (>=1)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   request pulse; sampled only in IDLE
//  op_write     in   1   1=store, 0=load
//  size         in   2   00 byte, 01 half, 11 word, 10 treated as word
//  addr         in   32  byte address
//  wdata        in   32  store data (byte/half in low bits)
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle completion pulse
//  misalign_err out  1   valid with done; see CONFIGURATION
//  mem_addr     out  32  {addr[31:2],2'b00}, held for whole access
//  mem_wr       out  1   memory write strobe
//  mem_wdata    out  32  word to write
//  mem_rdata    in   32  memory read data
//  word_out     out  32  captured word (feeds mux inputFull)
//  half_out     out  16  addr[1] ? word[31:16] : word[15:0]
//  byte_out     out  8   word[8*addr[1:0]+7 : 8*addr[1:0]]
//  size_out     out  2   size code of last completed load (feeds mux selector)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Async reset mid-access aborts; mem_wr drops at once; no later write.
//  Little-endian lanes: byte k = bits [8k+7:8k]. addr/op/size/wdata latched on accepted start.
//  FSM: IDLE -> READ (load, sb, sh) | WRITE (sw) | DONE (misaligned, trap build)
//       READ: MEM_LATENCY cycles, counter counts down; last cycle samples mem_rdata into MDR
//       READ -> DONE (load) | WRITE (sb/sh)
//       WRITE: 1 cycle, mem_wr=1, mem_wdata = merged word (sw: wdata) -> DONE
//       DONE: done=1 for 1 cycle -> IDLE. start during busy is ignored, never queued.
//  Latency (start in cycle 0): load done cycle 1+L; sw done cycle 2; sb/sh done cycle 2+L.
//  Merge: sb replaces lane addr[1:0] with wdata[7:0]; sh replaces half addr[1] with wdata[15:0].
//  word/half/byte/size_out update only when a load reaches DONE; held through stores and idle.
//  mem_wr never asserted outside WRITE; never on loads; never on misaligned access.
//  start with size=10 behaves exactly as size=11.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->DONE,
//   done=misalign_err=1 at cycle 1, no memory access, data outputs unchanged.
//  Undefined: low address bits ignored for lane selection of the misaligned size (half uses addr[1],
//   word uses aligned word); misalign_err tied 0.
// STRUCTURE
//  Shared header mem_defs.vh: SIZE_BYTE/SIZE_HALF/SIZE_WORD codes, FSM state encodings.
//  Sub-module mem_lane_merge: combinational merge (old word, wdata, size, addr[1:0]) -> new word.
//  Lane extraction and FSM stay in this module.
// TESTING
//  Load word addr=0x10, mem=0xDEADBEEF, L=1 -> done cycle 2, word_out=DEADBEEF, size_out=11, mem_wr=0 throughout.
//  Load byte addr=0x13, mem=0x80AA55CC -> byte_out=0x80, half_out=0x80AA, size_out=00.
//  sb addr=0x21 wdata=0x000000EE, mem=0x11223344 -> one WRITE, mem_wdata=0x1122EE44, done cycle 3.
//  sw addr=0x40 wdata=0xCAFEF00D, L=3 -> mem_wr cycle 1 only, done cycle 2; start pulsed while busy ignored.
//  With MISALIGN_TRAP_EN: lh addr=0x05 -> done+misalign_err cycle 1, no mem_wr, outputs unchanged.
//  rst_n low during READ of sh -> outputs 0 immediately, no mem_wr after release, state IDLE.

Source files
------------

// File: rtl/mem_load_store_seq_pkg.sv
// Shared size codes, FSM state encodings and helpers for the load/store sequencer.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
package mem_load_store_seq_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Code 10 is an alias of word; fold it once so the rest of the design sees three codes.
   function automatic logic [1:0] norm_size(input logic [1:0] s);
      return (s == 2'b10) ? SIZE_WORD : s;
   endfunction

endpackage

// File: rtl/mem_load_store_seq_if.sv
// Word-wide data-memory bus between the load/store sequencer (master) and memory (slave).
interface mem_load_store_seq_if;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (output mem_addr, output mem_wr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, input mem_wr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_load_store_seq_lane_merge.sv
// Combinational read-modify-write merge: drops store byte/half into the addressed lane of the old word.
module mem_lane_merge
   import mem_load_store_seq_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [15:0] new_data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] new_word
);

   always_comb begin
      new_word = old_word;
      if (size == SIZE_BYTE) begin
         case (lane)
            2'd0:    new_word[7:0]   = new_data[7:0];
            2'd1:    new_word[15:8]  = new_data[7:0];
            2'd2:    new_word[23:16] = new_data[7:0];
            default: new_word[31:24] = new_data[7:0];
         endcase
      end else if (size == SIZE_HALF) begin
         if (lane[1]) new_word[31:16] = new_data;
         else         new_word[15:0]  = new_data;
      end
   end

endmodule

// File: rtl/mem_load_store_seq.sv
// Multicycle load/store sequencer: word-aligned memory access, MDR lane extraction, sb/sh RMW.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring low address bits.
module mem_load_store_seq
   import mem_load_store_seq_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        op_write,
   input  logic [1:0]                  size,
   input  logic [31:0]                 addr,
   input  logic [31:0]                 wdata,
   output logic                        busy,
   output logic                        done,
   output logic                        misalign_err,
   mem_load_store_seq_if.master        mem,
   output logic [31:0]                 word_out,
   output logic [15:0]                 half_out,
   output logic [7:0]                  byte_out,
   output logic [1:0]                  size_out
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   logic [1:0]       state;
   logic             op_q;
   logic [1:0]       size_q;
   logic [1:0]       lane_q;
   logic [15:0]      wdata_q;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       req_size;
   logic             trap;
   logic [31:0]      merged;
   logic [15:0]      rd_half;
   logic [7:0]       rd_byte;

   assign req_size = norm_size(size);

`ifdef MISALIGN_TRAP_EN
   logic err_q;

   always_comb begin
      trap = 1'b0;
      if (req_size == SIZE_HALF)      trap = addr[0];
      else if (req_size == SIZE_WORD) trap = (addr[1:0] != 2'b00);
   end

   assign misalign_err = (state == S_DONE) && err_q;
`else
   assign trap         = 1'b0;
   assign misalign_err = 1'b0;
`endif

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   mem_lane_merge u_merge (
      .old_word (mem.mem_rdata),
      .new_data (wdata_q),
      .size     (size_q),
      .lane     (lane_q),
      .new_word (merged)
   );

   always_comb begin
      rd_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (lane_q)
         2'd0:    rd_byte = mem.mem_rdata[7:0];
         2'd1:    rd_byte = mem.mem_rdata[15:8];
         2'd2:    rd_byte = mem.mem_rdata[23:16];
         default: rd_byte = mem.mem_rdata[31:24];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         op_q          <= 1'b0;
         size_q        <= SIZE_BYTE;
         lane_q        <= 2'd0;
         wdata_q       <= '0;
         cnt           <= '0;
         mem.mem_addr  <= '0;
         mem.mem_wr    <= 1'b0;
         mem.mem_wdata <= '0;
         word_out      <= '0;
         half_out      <= '0;
         byte_out      <= '0;
         size_out      <= '0;
`ifdef MISALIGN_TRAP_EN
         err_q         <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q         <= op_write;
                  size_q       <= req_size;
                  lane_q       <= addr[1:0];
                  wdata_q      <= wdata[15:0];
                  cnt          <= CNT_INIT;
                  mem.mem_addr <= {addr[31:2], 2'b00};
`ifdef MISALIGN_TRAP_EN
                  err_q        <= trap;
`endif
                  // Full-word stores skip the read; the store word goes straight out.
                  if (trap) begin
                     state <= S_DONE;
                  end else if (op_write && req_size == SIZE_WORD) begin
                     state         <= S_WRITE;
                     mem.mem_wr    <= 1'b1;
                     mem.mem_wdata <= wdata;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (cnt == '0) begin
                  if (op_q) begin
                     state         <= S_WRITE;
                     mem.mem_wr    <= 1'b1;
                     mem.mem_wdata <= merged;
                  end else begin
                     state    <= S_DONE;
                     word_out <= mem.mem_rdata;
                     half_out <= rd_half;
                     byte_out <= rd_byte;
                     size_out <= size_q;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_WRITE: begin
               mem.mem_wr <= 1'b0;
               state      <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_load_store_seq.sv
// Directed bench for mem_load_store_seq: L=1 and L=3 instances driven in lockstep.
module tb_mem_load_store_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        op_write;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        busy1, done1, err1, busy3, done3, err3;
   logic [31:0] word1, word3;
   logic [15:0] half1, half3;
   logic [7:0]  byte1, byte3;
   logic [1:0]  size1, size3;

   logic [31:0] mem1 [0:255];
   logic [31:0] mem3 [0:255];

   int n_chk  = 0;
   int n_fail = 0;

   mem_load_store_seq_if bus1 ();
   mem_load_store_seq_if bus3 ();

   always #5 clk = ~clk;

   mem_load_store_seq #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .op_write(op_write), .size(size),
      .addr(addr), .wdata(wdata), .busy(busy1), .done(done1), .misalign_err(err1),
      .mem(bus1), .word_out(word1), .half_out(half1), .byte_out(byte1), .size_out(size1)
   );

   mem_load_store_seq #(.MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .op_write(op_write), .size(size),
      .addr(addr), .wdata(wdata), .busy(busy3), .done(done3), .misalign_err(err3),
      .mem(bus3), .word_out(word3), .half_out(half3), .byte_out(byte3), .size_out(size3)
   );

   // Behavioural word memories, one per instance.
   assign bus1.mem_rdata = mem1[bus1.mem_addr[9:2]];
   assign bus3.mem_rdata = mem3[bus3.mem_addr[9:2]];

   always @(posedge clk) begin
      if (bus1.mem_wr) mem1[bus1.mem_addr[9:2]] = bus1.mem_wdata;
      if (bus3.mem_wr) mem3[bus3.mem_addr[9:2]] = bus3.mem_wdata;
   end

   typedef struct {
      logic        opw;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic        pre;
      logic [31:0] pre_word;
      bit          hold;
      int          d1;
      int          d3;
      int          nw;
      int          wc1;
      int          wc3;
      logic [31:0] x_word;
      logic [15:0] x_half;
      logic [7:0]  x_byte;
      logic [1:0]  x_size;
      logic [31:0] x_mem;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " busy1"},  32'(busy1), 0);
      chk({tag, " done1"},  32'(done1), 0);
      chk({tag, " err1"},   32'(err1), 0);
      chk({tag, " wr1"},    32'(bus1.mem_wr), 0);
      chk({tag, " maddr1"}, bus1.mem_addr, 0);
      chk({tag, " mwd1"},   bus1.mem_wdata, 0);
      chk({tag, " word1"},  word1, 0);
      chk({tag, " half1"},  32'(half1), 0);
      chk({tag, " byte1"},  32'(byte1), 0);
      chk({tag, " size1"},  32'(size1), 0);
      chk({tag, " busy3"},  32'(busy3), 0);
      chk({tag, " wr3"},    32'(bus3.mem_wr), 0);
      chk({tag, " word3"},  word3, 0);
      chk({tag, " half3"},  32'(half3), 0);
      chk({tag, " byte3"},  32'(byte3), 0);
      chk({tag, " size3"},  32'(size3), 0);
   endtask

   // Starts one access in the current cycle (cycle 0) and runs until both instances finish.
   task automatic run_access(input logic opw, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input bit hold,
                             output int d1, output int d3, output int w1, output int w3,
                             output int wc1, output int wc3, output logic e1, output logic e3);
      d1 = 0; d3 = 0; w1 = 0; w3 = 0; wc1 = 0; wc3 = 0; e1 = 1'b0; e3 = 1'b0;
      op_write = opw; size = sz; addr = a; wdata = wd; start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (!hold || c >= 2) start = 1'b0;
         if (bus1.mem_wr) begin w1++; wc1 = c; end
         if (bus3.mem_wr) begin w3++; wc3 = c; end
         if (done1 && d1 == 0) begin d1 = c; e1 = err1; end
         if (done3 && d3 == 0) begin d3 = c; e3 = err3; end
         if (d1 != 0 && d3 != 0) break;
      end
      start = 1'b0;
   endtask

   int          d1, d3, w1, w3, wc1, wc3;
   logic        e1, e3;
   logic [7:0]  ix;

   initial begin
      vecs[0]  = '{1'b0, 2'b11, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2, 4, 0, 0, 0, 32'hDEADBEEF, 16'hBEEF, 8'hEF, 2'b11, 32'hDEADBEEF};
      vecs[1]  = '{1'b0, 2'b00, 32'h13, 32'h0,        1'b1, 32'h80AA55CC, 1'b0, 2, 4, 0, 0, 0, 32'h80AA55CC, 16'h80AA, 8'h80, 2'b00, 32'h80AA55CC};
      vecs[2]  = '{1'b1, 2'b00, 32'h21, 32'h000000EE, 1'b1, 32'h11223344, 1'b0, 3, 5, 1, 2, 4, 32'h80AA55CC, 16'h80AA, 8'h80, 2'b00, 32'h1122EE44};
      vecs[3]  = '{1'b1, 2'b11, 32'h40, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b1, 2, 2, 1, 1, 1, 32'h80AA55CC, 16'h80AA, 8'h80, 2'b00, 32'hCAFEF00D};
      vecs[4]  = '{1'b1, 2'b01, 32'h32, 32'h0000BEEF, 1'b1, 32'h01234567, 1'b0, 3, 5, 1, 2, 4, 32'h80AA55CC, 16'h80AA, 8'h80, 2'b00, 32'hBEEF4567};
      vecs[5]  = '{1'b0, 2'b01, 32'h32, 32'h0,        1'b0, 32'h00000000, 1'b0, 2, 4, 0, 0, 0, 32'hBEEF4567, 16'hBEEF, 8'hEF, 2'b01, 32'hBEEF4567};
      vecs[6]  = '{1'b0, 2'b10, 32'h44, 32'h0,        1'b1, 32'h12345678, 1'b0, 2, 4, 0, 0, 0, 32'h12345678, 16'h5678, 8'h78, 2'b11, 32'h12345678};
      vecs[7]  = '{1'b0, 2'b00, 32'h7E, 32'h0,        1'b1, 32'hA1B2C3D4, 1'b0, 2, 4, 0, 0, 0, 32'hA1B2C3D4, 16'hA1B2, 8'hB2, 2'b00, 32'hA1B2C3D4};
      vecs[8]  = '{1'b1, 2'b01, 32'h50, 32'hFFFF1234, 1'b1, 32'hAAAAAAAA, 1'b0, 3, 5, 1, 2, 4, 32'hA1B2C3D4, 16'hA1B2, 8'hB2, 2'b00, 32'hAAAA1234};
      vecs[9]  = '{1'b1, 2'b00, 32'h63, 32'h0000005A, 1'b1, 32'h00000000, 1'b0, 3, 5, 1, 2, 4, 32'hA1B2C3D4, 16'hA1B2, 8'hB2, 2'b00, 32'h5A000000};
      vecs[10] = '{1'b0, 2'b00, 32'h63, 32'h0,        1'b0, 32'h00000000, 1'b0, 2, 4, 0, 0, 0, 32'h5A000000, 16'h5A00, 8'h5A, 2'b00, 32'h5A000000};

      for (int k = 0; k < 256; k++) begin
         mem1[k] = 32'h0;
         mem3[k] = 32'h0;
      end
      rst_n = 1'b0; start = 1'b0; op_write = 1'b0; size = 2'b00; addr = '0; wdata = '0;
      repeat (3) step();
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < NV; i++) begin
         ix = vecs[i].a[9:2];
         if (vecs[i].pre) begin
            mem1[ix] = vecs[i].pre_word;
            mem3[ix] = vecs[i].pre_word;
         end
         run_access(vecs[i].opw, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].hold,
                    d1, d3, w1, w3, wc1, wc3, e1, e3);
         chk($sformatf("v%0d done_cyc1", i), d1, vecs[i].d1);
         chk($sformatf("v%0d done_cyc3", i), d3, vecs[i].d3);
         chk($sformatf("v%0d writes1", i), w1, vecs[i].nw);
         chk($sformatf("v%0d writes3", i), w3, vecs[i].nw);
         chk($sformatf("v%0d wr_cyc1", i), wc1, vecs[i].wc1);
         chk($sformatf("v%0d wr_cyc3", i), wc3, vecs[i].wc3);
         chk($sformatf("v%0d err1", i), 32'(e1), 0);
         chk($sformatf("v%0d err3", i), 32'(e3), 0);
         chk($sformatf("v%0d word1", i), word1, vecs[i].x_word);
         chk($sformatf("v%0d word3", i), word3, vecs[i].x_word);
         chk($sformatf("v%0d half1", i), 32'(half1), 32'(vecs[i].x_half));
         chk($sformatf("v%0d half3", i), 32'(half3), 32'(vecs[i].x_half));
         chk($sformatf("v%0d byte1", i), 32'(byte1), 32'(vecs[i].x_byte));
         chk($sformatf("v%0d byte3", i), 32'(byte3), 32'(vecs[i].x_byte));
         chk($sformatf("v%0d size1", i), 32'(size1), 32'(vecs[i].x_size));
         chk($sformatf("v%0d size3", i), 32'(size3), 32'(vecs[i].x_size));
         chk($sformatf("v%0d mem1", i), mem1[ix], vecs[i].x_mem);
         chk($sformatf("v%0d mem3", i), mem3[ix], vecs[i].x_mem);
         step();
         chk($sformatf("v%0d idle1", i), 32'(busy1), 0);
         chk($sformatf("v%0d idle3", i), 32'(busy3), 0);
      end

      // Misaligned halfword load at 0x05.
      mem1[1] = 32'h0000ABCD;
      mem3[1] = 32'h0000ABCD;
      run_access(1'b0, 2'b01, 32'h05, 32'h0, 1'b0, d1, d3, w1, w3, wc1, wc3, e1, e3);
      chk("mis writes1", w1, 0);
      chk("mis writes3", w3, 0);
`ifdef MISALIGN_TRAP_EN
      chk("mis done_cyc1", d1, 1);
      chk("mis done_cyc3", d3, 1);
      chk("mis err1", 32'(e1), 1);
      chk("mis err3", 32'(e3), 1);
      chk("mis word1", word1, 32'h5A000000);
      chk("mis half3", 32'(half3), 32'h5A00);
      chk("mis size1", 32'(size1), 0);
`else
      chk("mis done_cyc1", d1, 2);
      chk("mis done_cyc3", d3, 4);
      chk("mis err1", 32'(e1), 0);
      chk("mis err3", 32'(e3), 0);
      chk("mis half1", 32'(half1), 32'hABCD);
      chk("mis byte3", 32'(byte3), 32'hAB);
      chk("mis size1", 32'(size1), 1);
`endif
      step();

      // Asynchronous reset while an sh is in flight (L=1 instance is in WRITE, L=3 in READ).
      mem1[12] = 32'hBEEF4567;
      mem3[12] = 32'hBEEF4567;
      op_write = 1'b1; size = 2'b01; addr = 32'h30; wdata = 32'h00001111; start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("rst pre wr1", 32'(bus1.mem_wr), 1);
      chk("rst pre busy3", 32'(busy3), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      w1 = 0; w3 = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (bus1.mem_wr || busy1) w1++;
         if (bus3.mem_wr || busy3) w3++;
      end
      chk("rst quiet1", w1, 0);
      chk("rst quiet3", w3, 0);
      chk("rst mem1", mem1[12], 32'hBEEF4567);
      chk("rst mem3", mem3[12], 32'hBEEF4567);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
